// File: rtl/spi_fifo_drain_if.sv
// FIFO read port, SPI pins and response strobe for spi_fifo_drain.
// The master modport is the drain's view; slave is the FIFO/SPI-device side.
interface spi_fifo_drain_if #(parameter int DATA_WIDTH = 41);
  logic                  spi_enable;
  logic                  fifo_empty;
  logic                  fifo_rd_en;
  logic [DATA_WIDTH-1:0] fifo_rd_data;
  logic                  spi_sclk;
  logic                  spi_cs_n;
  logic                  spi_mosi;
  logic                  spi_miso;
  logic [31:0]           resp_data;
  logic                  resp_valid;
  logic                  busy;

  modport master (
    input  spi_enable, fifo_empty, fifo_rd_data, spi_miso,
    output fifo_rd_en, spi_sclk, spi_cs_n, spi_mosi, resp_data, resp_valid, busy
  );

  modport slave (
    output spi_enable, fifo_empty, fifo_rd_data, spi_miso,
    input  fifo_rd_en, spi_sclk, spi_cs_n, spi_mosi, resp_data, resp_valid, busy
  );
endinterface

// File: rtl/spi_fifo_drain.sv
// Pops command words from the read side of the AHB-to-SPI FIFO and plays each out as an
// SPI mode-0 frame, MSB first. Define SPI_LOOPBACK_EN to feed rx from spi_mosi instead of spi_miso.
module spi_fifo_drain #(
  parameter int DATA_WIDTH = 41,
  parameter int CLK_DIV    = 4,
  parameter int CS_GAP     = 2
) (
  input logic           rd_clk,
  input logic           rd_rst_n,
  spi_fifo_drain_if.master bus
);
  localparam int              CW       = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0]   LAST_BIT = CW'(DATA_WIDTH);
  localparam logic [7:0]      DIV_END  = 8'(CLK_DIV - 1);
  localparam logic [7:0]      GAP_END  = 8'(CS_GAP - 1);

  typedef enum logic [2:0] {IDLE, POP, LOAD, SHIFT, GAP} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [31:0]           rx_reg;
  logic                  cmd_rw;
  logic [CW-1:0]         bit_cnt;
  logic [7:0]            div_cnt;
  logic [7:0]            gap_cnt;
  logic                  rd_en, sclk, cs_n, mosi, resp_valid, busy;
  logic [31:0]           resp_data;
  logic                  rx_bit;

`ifdef SPI_LOOPBACK_EN
  assign rx_bit = mosi;
`else
  assign rx_bit = bus.spi_miso;
`endif

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      state      <= IDLE;
      shift_reg  <= '0;
      rx_reg     <= '0;
      cmd_rw     <= 1'b0;
      bit_cnt    <= '0;
      div_cnt    <= '0;
      gap_cnt    <= '0;
      rd_en      <= 1'b0;
      sclk       <= 1'b0;
      cs_n       <= 1'b1;
      mosi       <= 1'b0;
      resp_data  <= '0;
      resp_valid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      rd_en      <= 1'b0;
      resp_valid <= 1'b0;
      case (state)
        IDLE: if (bus.spi_enable && !bus.fifo_empty) begin
          rd_en <= 1'b1;
          busy  <= 1'b1;
          state <= POP;
        end
        POP: state <= LOAD;
        LOAD: begin
          shift_reg <= bus.fifo_rd_data;
          cmd_rw    <= bus.fifo_rd_data[DATA_WIDTH-1];
          mosi      <= bus.fifo_rd_data[DATA_WIDTH-1];
          cs_n      <= 1'b0;
          bit_cnt   <= '0;
          div_cnt   <= '0;
          state     <= SHIFT;
        end
        SHIFT: begin
          // Final low phase has elapsed once sclk is back low with every bit sampled.
          if (!sclk && bit_cnt == LAST_BIT) begin
            cs_n    <= 1'b1;
            mosi    <= 1'b0;
            gap_cnt <= '0;
            state   <= GAP;
            if (!cmd_rw) begin
              resp_valid <= 1'b1;
              resp_data  <= rx_reg;
            end
          end else if (div_cnt == DIV_END) begin
            div_cnt <= '0;
            if (!sclk) begin
              sclk    <= 1'b1;
              rx_reg  <= {rx_reg[30:0], rx_bit};
              bit_cnt <= bit_cnt + 1'b1;
            end else begin
              sclk <= 1'b0;
              if (bit_cnt != LAST_BIT) begin
                shift_reg <= {shift_reg[DATA_WIDTH-2:0], shift_reg[DATA_WIDTH-1]};
                mosi      <= shift_reg[DATA_WIDTH-2];
              end
            end
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        GAP: begin
          if (gap_cnt == GAP_END) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.fifo_rd_en = rd_en;
  assign bus.spi_sclk   = sclk;
  assign bus.spi_cs_n   = cs_n;
  assign bus.spi_mosi   = mosi;
  assign bus.resp_data  = resp_data;
  assign bus.resp_valid = resp_valid;
  assign bus.busy       = busy;
endmodule

// File: tb/tb_spi_fifo_drain.sv
// Bench for spi_fifo_drain: FIFO and SPI slave models plus a cycle-accurate frame model
// derived from pop times, checked every cycle at the falling clock edge.
module tb_spi_fifo_drain;
  localparam int DW    = 41;
  localparam int CD    = 4;
  localparam int G     = 2;
  localparam int F     = 2 * CD * DW + 1;

  logic rd_clk = 1'b0;
  logic rd_rst_n;
  always #5 rd_clk = ~rd_clk;

  spi_fifo_drain_if #(.DATA_WIDTH(DW)) bus ();

  spi_fifo_drain #(.DATA_WIDTH(DW), .CLK_DIV(CD), .CS_GAP(G)) dut (
    .rd_clk  (rd_clk),
    .rd_rst_n(rd_rst_n),
    .bus     (bus)
  );

  int n_vec = 0, n_bad = 0, cyc = 0;
  logic [DW-1:0] fq[$];

  // frame model
  bit active, en_prev, empty_prev, have_prev, ready, pend_pop;
  int p_cyc, idle_from, prev_pop;
  logic [DW-1:0] m_word, m_spat;
  logic [31:0] m_resp;
  // pin observer
  int cs_run, rises;
  logic [DW-1:0] mosi_cap;
  bit prev_sclk_o;
  // slave
  logic [DW-1:0] spat, next_spat;
  int bidx;
  bit s_cs, s_sclk;

  function automatic logic [DW-1:0] rand_word();
    return DW'({$urandom(), $urandom()});
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, act, exp);
    end
  endtask

  task automatic check_cycle();
    int t, k;
    bit e_rd, e_cs, e_sclk, e_mosi, e_rv, e_busy;
    cyc++;
    pend_pop = bus.fifo_rd_en;
    if (!rd_rst_n) begin
      chk("reset_pins", 64'({bus.fifo_rd_en, bus.spi_sclk, bus.spi_cs_n, bus.spi_mosi,
                             bus.resp_valid, bus.busy}), 64'(6'b001000));
      chk("reset_resp", 64'(bus.resp_data), 64'(0));
      active = 0; have_prev = 0; ready = 0; m_resp = '0; idle_from = cyc + 1;
      cs_run = 0; rises = 0; en_prev = 0; empty_prev = 1; prev_sclk_o = 0;
      return;
    end
    e_rd = (cyc - 1 >= idle_from) && en_prev && !empty_prev;
    if (bus.fifo_rd_en) begin
      chk("rd_en_nonempty", 64'(bus.fifo_empty), 64'(0));
      if (have_prev && ready) chk("pop_spacing", 64'(cyc - prev_pop), 64'(334));
      m_word    = (fq.size() > 0) ? fq[0] : '0;
      active    = 1;
      p_cyc     = cyc;
      idle_from = cyc + F + G + 2;
      have_prev = 1;
      prev_pop  = cyc;
      ready     = 0;
    end
    if (active && cyc == idle_from) ready = bus.spi_enable && !bus.fifo_empty;
    t = cyc - (p_cyc + 2);
    if (active && t == 0) m_spat = spat;
    e_cs   = !(active && t >= 0 && t < F);
    e_sclk = active && t >= 0 && t < F - 1 && ((t / CD) % 2 == 1);
    e_mosi = 1'b0;
    if (!e_cs) begin
      k = t / (2 * CD);
      if (k >= DW) k = DW - 1;
      e_mosi = 1'(m_word >> (DW - 1 - k));
    end
    e_rv   = active && t == F && !m_word[DW-1];
    e_busy = active && cyc < idle_from;
    if (e_rv) begin
`ifdef SPI_LOOPBACK_EN
      m_resp = m_word[31:0];
`else
      m_resp = m_spat[31:0];
`endif
    end
    chk("pins", 64'({bus.fifo_rd_en, bus.spi_sclk, bus.spi_cs_n, bus.spi_mosi,
                     bus.resp_valid, bus.busy}),
        64'({e_rd, e_sclk, e_cs, e_mosi, e_rv, e_busy}));
    chk("resp_data", 64'(bus.resp_data), 64'(m_resp));
`ifdef SPI_LOOPBACK_EN
    if (e_rv && m_word == 41'h0_01_CAFEF00D)
      chk("loopback_literal", 64'(bus.resp_data), 64'(32'hCAFEF00D));
`else
    if (e_rv && m_word == 41'h0_3C_00000000)
      chk("read_literal", 64'(bus.resp_data), 64'(32'h12345678));
`endif
    if (!bus.spi_cs_n) begin
      cs_run++;
      if (bus.spi_sclk && !prev_sclk_o) begin
        rises++;
        mosi_cap = {mosi_cap[DW-2:0], bus.spi_mosi};
      end
    end else if (cs_run > 0) begin
      chk("cs_low_len", 64'(cs_run), 64'(329));
      chk("sclk_pulses", 64'(rises), 64'(41));
      chk("mosi_frame", 64'(mosi_cap), 64'(m_word));
      cs_run = 0;
      rises  = 0;
    end
    prev_sclk_o = bus.spi_sclk;
    en_prev     = bus.spi_enable;
    empty_prev  = bus.fifo_empty;
  endtask

  task automatic step();
    @(negedge rd_clk);
    check_cycle();
    @(posedge rd_clk);
    #1;
    if (pend_pop && fq.size() > 0) bus.fifo_rd_data = fq.pop_front();
    bus.fifo_empty = (fq.size() == 0);
    if (s_cs && !bus.spi_cs_n) begin
      spat         = next_spat;
      bidx         = 0;
      bus.spi_miso = spat[DW-1];
      next_spat    = rand_word();
    end else if (!bus.spi_cs_n && s_sclk && !bus.spi_sclk) begin
      bidx++;
      if (bidx < DW) bus.spi_miso = 1'(spat >> (DW - 1 - bidx));
    end
    s_cs   = bus.spi_cs_n;
    s_sclk = bus.spi_sclk;
  endtask

  task automatic push(input logic [DW-1:0] w);
    fq.push_back(w);
    bus.fifo_empty = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((fq.size() > 0 || bus.busy || bus.fifo_rd_en) && n < budget) begin
      step();
      n++;
    end
    repeat (4) step();
    chk("drain_done", 64'(fq.size() == 0 && !bus.busy), 64'(1));
  endtask

  task automatic wait_cs_low(input int budget);
    int n = 0;
    while (bus.spi_cs_n && n < budget) begin
      step();
      n++;
    end
    chk("cs_fall_seen", 64'(!bus.spi_cs_n), 64'(1));
  endtask

  initial begin
    logic [DW-1:0] w;
    rd_rst_n = 1'b0;
    bus.spi_enable = 1'b0;
    bus.fifo_empty = 1'b1;
    bus.fifo_rd_data = '0;
    bus.spi_miso = 1'b0;
    s_cs = 1; s_sclk = 0; bidx = 0; spat = '0;
    next_spat = rand_word();
    idle_from = 0; active = 0; m_resp = '0; mosi_cap = '0; m_word = '0; m_spat = '0;

    // reset held with data waiting, then released with enable low
    push(41'h1_A5_DEADBEEF);
    repeat (5) step();
    rd_rst_n = 1'b1;
    repeat (10) step();
    bus.spi_enable = 1'b1;
    drain(2000);

    // directed read with known slave pattern
    next_spat = {9'h155, 32'h12345678};
    push(41'h0_3C_00000000);
    drain(2000);

    // back-to-back
    repeat (3) push(rand_word());
    drain(3000);

    // enable dropped at bit 10
    push(rand_word());
    push(rand_word());
    wait_cs_low(100);
    repeat (2 * CD * 10) step();
    bus.spi_enable = 1'b0;
    repeat (F + G + 40) step();
    bus.spi_enable = 1'b1;
    drain(2000);

    // reset pulsed at bit 20 during a read
    w = rand_word();
    w[DW-1] = 1'b0;
    push(w);
    push(rand_word());
    wait_cs_low(100);
    repeat (2 * CD * 20) step();
    rd_rst_n = 1'b0;
    repeat (3) step();
    rd_rst_n = 1'b1;
    drain(2000);

    // loopback word
    push(41'h0_01_CAFEF00D);
    drain(2000);

    // random traffic and enable toggling
    repeat (12) begin
      repeat ($urandom_range(1, 3)) push(rand_word());
      repeat ($urandom_range(50, 900)) begin
        step();
        bus.spi_enable = ($urandom_range(0, 4) != 0);
      end
    end
    bus.spi_enable = 1'b1;
    drain(20000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
